// File: rtl/fir_coeff_load_ctrl.sv
// Coefficient reload sequencer: streams NUM_TAPS beats into the FIR coefficient array
// and holds the datapath while loading. Optional checksum accumulator under COEFF_CHECKSUM_EN.
module fir_coeff_load_ctrl #(
  parameter int NUM_TAPS = 71,
  parameter int COEFF_W  = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      s_valid,
  input  logic signed [COEFF_W-1:0] s_data,
  output logic                      s_ready,
  output logic        [ADDR_W-1:0]  coef_addr,
  output logic signed [COEFF_W-1:0] coef_data,
  output logic                      coef_we,
  output logic                      dp_hold,
  output logic                      busy,
  output logic                      done,
  output logic                      aborted,
  output logic        [ADDR_W-1:0]  load_count,
  output logic signed [15:0]        checksum
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic        [ADDR_W-1:0]  addr;
    logic signed [COEFF_W-1:0] data;
  } coef_wr_t;

  logic [1:0] state;
  coef_wr_t   wr;
  logic       load_go;
  logic       beat_acc;
  logic       last_beat;

  assign load_go   = (state == S_IDLE) & start & ~abort;
  assign s_ready   = (state == S_LOAD) & ~abort;
  assign beat_acc  = s_valid & s_ready;
  assign last_beat = beat_acc & (load_count == ADDR_W'(NUM_TAPS - 1));

  assign busy      = (state == S_LOAD) | (state == S_DONE);
  assign dp_hold   = busy;
  assign done      = (state == S_DONE);
  assign coef_addr = wr.addr;
  assign coef_data = wr.data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wr         <= '0;
      coef_we    <= 1'b0;
      aborted    <= 1'b0;
      load_count <= '0;
    end else begin
      coef_we <= beat_acc;
      aborted <= 1'b0;
      // write address is the pre-increment count; data/addr hold between writes
      if (beat_acc) begin
        wr         <= '{addr: load_count, data: s_data};
        load_count <= load_count + 1'b1;
      end else if (load_go) begin
        load_count <= '0;
      end
      case (state)
        S_IDLE: if (load_go) state <= S_LOAD;
        S_LOAD: begin
          if (abort) begin
            state   <= S_IDLE;
            aborted <= 1'b1;
          end else if (last_beat) begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef COEFF_CHECKSUM_EN
  logic signed [15:0] csum;

  always_ff @(posedge clk) begin
    if (rst || load_go) csum <= '0;
    else if (beat_acc)  csum <= csum + {{(16-COEFF_W){s_data[COEFF_W-1]}}, s_data};
  end

  assign checksum = csum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_fir_coeff_load_ctrl.sv
// Randomized bench for fir_coeff_load_ctrl: a transaction-level model predicts the
// write sequence, pulse counts and final count/checksum of each load scenario.
module tb_fir_coeff_load_ctrl;
  localparam int NUM_TAPS = 71;
  localparam int COEFF_W  = 8;
  localparam int ADDR_W   = 7;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic signed [COEFF_W-1:0] s_data = '0;
  logic s_ready, coef_we, dp_hold, busy, done, aborted;
  logic        [ADDR_W-1:0]  coef_addr, load_count;
  logic signed [COEFF_W-1:0] coef_data;
  logic signed [15:0]        checksum;

  fir_coeff_load_ctrl #(.NUM_TAPS(NUM_TAPS), .COEFF_W(COEFF_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .s_valid(s_valid),
    .s_data(s_data), .s_ready(s_ready), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_we(coef_we), .dp_hold(dp_hold), .busy(busy), .done(done), .aborted(aborted),
    .load_count(load_count), .checksum(checksum)
  );

  typedef struct { int addr; int data; } wr_t;

  int  errs = 0, checks = 0, cyc = 0;
  int  done_cnt, abrt_cnt, done_cyc;
  int  last_addr = 0, last_data = 0;
  bit  rst_d = 1'b1;
  wr_t wr_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
  end

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // passive monitor: collects writes and pulses, checks per-cycle invariants
  always @(negedge clk) begin
    chk("dp_hold_eq_busy", int'(dp_hold), int'(busy));
    if (rst_d) begin
      last_addr = 0;
      last_data = 0;
    end else if (coef_we) begin
      wr_q.push_back('{int'(coef_addr), int'(coef_data)});
      last_addr = int'(coef_addr);
      last_data = int'(coef_data);
    end else begin
      chk("addr_hold", int'(coef_addr), last_addr);
      chk("data_hold", int'(coef_data), last_data);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("done_with_we", int'(coef_we), 1);
      chk("done_last_addr", int'(coef_addr), NUM_TAPS - 1);
    end
    if (aborted) abrt_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ":s_ready"}, int'(s_ready), 0);
    chk({nm, ":coef_we"}, int'(coef_we), 0);
    chk({nm, ":dp_hold"}, int'(dp_hold), 0);
    chk({nm, ":busy"}, int'(busy), 0);
    chk({nm, ":done"}, int'(done), 0);
    chk({nm, ":aborted"}, int'(aborted), 0);
    chk({nm, ":coef_addr"}, int'(coef_addr), 0);
    chk({nm, ":coef_data"}, int'(coef_data), 0);
    chk({nm, ":load_count"}, int'(load_count), 0);
    chk({nm, ":checksum"}, int'(checksum), 0);
  endtask

  // gap_mode: 0 continuous, 1 alternating, 2 random; data_mode: 0 k, 1 -1, 2 random
  task automatic do_load(input string nm, input int gap_mode, input int data_mode,
                         input int abort_after, input int rst_after, input int mid_start);
    int  beats = 0, budget = 0, t0, sum = 0, exp_cs;
    bit  stop = 1'b0, was_abort = 1'b0, was_rst = 1'b0;
    int  exp_q[$];
    wr_q.delete();
    done_cnt = 0; abrt_cnt = 0; done_cyc = -1;
    t0 = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({nm, ":busy_after_start"}, int'(busy), 1);
    chk({nm, ":ready_after_start"}, int'(s_ready), 1);
    chk({nm, ":count_cleared"}, int'(load_count), 0);
    chk({nm, ":cs_cleared"}, int'(checksum), 0);
    while (!stop && beats < NUM_TAPS) begin
      bit v;
      logic signed [COEFF_W-1:0] d;
      budget++;
      if (budget > 4000) begin
        chk({nm, ":timeout"}, beats, NUM_TAPS);
        stop = 1'b1;
      end else if (beats == abort_after) begin
        abort = 1'b1; s_valid = 1'b1;
        step();
        abort = 1'b0; s_valid = 1'b0;
        chk({nm, ":aborted_pulse"}, int'(aborted), 1);
        chk({nm, ":busy_after_abort"}, int'(busy), 0);
        was_abort = 1'b1;
        stop = 1'b1;
      end else if (beats == rst_after) begin
        rst = 1'b1; s_valid = 1'b1;
        step();
        chk_zero({nm, ":rst1"});
        step();
        chk_zero({nm, ":rst2"});
        rst = 1'b0; s_valid = 1'b0;
        was_rst = 1'b1;
        stop = 1'b1;
      end else begin
        case (gap_mode)
          0:       v = 1'b1;
          1:       v = (budget % 2) == 1;
          default: v = $urandom_range(1, 0) == 1;
        endcase
        case (data_mode)
          0:       d = COEFF_W'(beats);
          1:       d = -8'sd1;
          default: d = COEFF_W'($urandom);
        endcase
        s_valid = v;
        s_data  = d;
        start   = (beats == mid_start);
        step();
        if (v) begin
          exp_q.push_back(int'(d));
          sum += int'(d);
          beats++;
        end
        chk({nm, ":s_ready"}, int'(s_ready), int'(beats < NUM_TAPS));
        chk({nm, ":done_now"}, int'(done), int'(beats == NUM_TAPS));
      end
    end
    s_valid = 1'b0; start = 1'b0;
    if (beats == NUM_TAPS) begin
      step();
      chk({nm, ":dp_hold_fall"}, int'(dp_hold), 0);
      chk({nm, ":done_gone"}, int'(done), 0);
      if (gap_mode == 0) chk({nm, ":min_latency"}, done_cyc - t0, NUM_TAPS + 1);
    end
    repeat (4) step();
    chk({nm, ":n_writes"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      chk({nm, ":wr_addr"}, wr_q[i].addr, i);
      chk({nm, ":wr_data"}, wr_q[i].data, exp_q[i]);
    end
    chk({nm, ":done_cnt"}, done_cnt, int'(beats == NUM_TAPS && !was_rst));
    chk({nm, ":abort_cnt"}, abrt_cnt, int'(was_abort));
    chk({nm, ":load_count"}, int'(load_count), was_rst ? 0 : beats);
`ifdef COEFF_CHECKSUM_EN
    exp_cs = was_rst ? 0 : sum;
`else
    exp_cs = 0;
`endif
    chk({nm, ":checksum"}, int'(checksum), exp_cs);
    chk({nm, ":idle_busy"}, int'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    step();
    start = 1'b1; s_valid = 1'b1;
    step();
    chk_zero("reset1");
    start = 1'b0; s_valid = 1'b0;
    step();
    chk_zero("reset2");
    rst = 1'b0;
    step();
    chk_zero("idle");

    do_load("full",     0, 0, -1, -1, -1);
    do_load("backpres", 1, 1, -1, -1, -1);
    do_load("abort",    0, 2, 10, -1, -1);
    do_load("reload",   0, 0, -1, -1, -1);
    do_load("midstart", 2, 2, -1, -1, 20);

    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("start_abort:busy", int'(busy), 0);
    chk("start_abort:s_ready", int'(s_ready), 0);
    chk("start_abort:aborted", int'(aborted), 0);
    step();
    chk("start_abort:still_idle", int'(busy), 0);

    do_load("rst_mid",  0, 2, -1, 31, -1);
    do_load("rand_ab",  2, 2, int'($urandom_range(60, 1)), -1, -1);
    do_load("random",   2, 2, -1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
